fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_next_pc_sel.sv | 28 ++
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/IF-ID definitions: address and instruction widths,
// the NOP word, the reset PC and a wrapping PC increment.
package fetch_stage_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 19;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = 19'd0;
    localparam pc_t    RESET_PC  = 12'h000;

    // Modulo-4096 increment; the carry out is simply dropped.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority select for the fetch stage (purely combinational).
// Ports: pc_i current fetch PC, stall_i, branch_taken_i/branch_target_i,
//        jump_i/jump_target_i in; next_pc_o selected next fetch PC out.
module next_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic [PC_W-1:0] next_pc_o
);

    // Branch beats jump, any redirect beats a stall.
    always_comb begin
        next_pc_o = pc_inc(pc_i);
        if (branch_taken_i) begin
            next_pc_o = branch_target_i;
        end else if (jump_i) begin
            next_pc_o = jump_target_i;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-cycle synchronous instruction memory.
// Ports: clk, reset (sync, active-high), stall, branch_taken/branch_target,
//        jump/jump_target in; imem_addr out, imem_data in; instruction,
//        pc_out, flush, loadbar out towards the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc_out,
    output logic               flush,
    output logic               loadbar
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            valid_q, valid_d;
    logic            redirect;
    logic            hold;

    assign redirect = branch_taken | jump;
    assign hold     = stall & ~redirect;

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .next_pc_o       (pc_d)
    );

    // A redirect issues the read but marks it wrong-path so it
    // reaches IF/ID as a NOP; a stall keeps the outstanding read.
    always_comb begin
        req_pc_d = pc_q;
        valid_d  = 1'b1;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (stall) begin
            req_pc_d = req_pc_q;
            valid_d  = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            valid_q  <= valid_d;
        end
    end

    // Re-presenting the held address keeps imem_data stable in a stall.
    assign imem_addr   = hold ? req_pc_q : pc_q;
    assign instruction = valid_q ? imem_data : NOP_INSTR;
    assign pc_out      = pc_inc(req_pc_q);
    assign flush       = redirect & ~reset;
    assign loadbar     = hold;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: per-cycle expected outputs are
// queued with the stimulus and popped when the DUT outputs settle.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        jump;
    logic [11:0] jump_target;
    logic [11:0] imem_addr;
    logic [18:0] imem_data;
    logic [18:0] instruction;
    logic [11:0] pc_out;
    logic        flush;
    logic        loadbar;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [11:0] addr;
        logic [18:0] ins;
        logic [11:0] pco;
        logic        fl;
        logic        lb;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Synchronous memory: word at address a reads as 19'h100 + a.
    always @(posedge clk)
        imem_data <= 19'h100 + {7'd0, imem_addr};

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .flush         (flush),
        .loadbar       (loadbar)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle at the falling edge, queue the expectation,
    // compare once the combinational outputs have settled.
    task automatic step(input string tag,
                        input logic rst, input logic st,
                        input logic br, input logic [11:0] bt,
                        input logic jp, input logic [11:0] jt,
                        input logic [11:0] e_addr, input logic [18:0] e_ins,
                        input logic [11:0] e_pco,
                        input logic e_fl, input logic e_lb);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        e.addr = e_addr;
        e.ins  = e_ins;
        e.pco  = e_pco;
        e.fl   = e_fl;
        e.lb   = e_lb;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check({tag, ".addr"}, 32'(imem_addr), 32'(e.addr));
        check({tag, ".ins"},  32'(instruction), 32'(e.ins));
        check({tag, ".pco"},  32'(pc_out), 32'(e.pco));
        check({tag, ".fl"},   32'(flush), 32'(e.fl));
        check({tag, ".lb"},   32'(loadbar), 32'(e.lb));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        @(posedge clk);
        // Held in reset: state already cleared.
        step("rst",   1,0, 0,12'h0, 0,12'h0, 12'h000,19'h0,    12'h001,0,0);
        // Free run from 0.
        step("run0",  0,0, 0,12'h0, 0,12'h0, 12'h000,19'h0,    12'h001,0,0);
        step("run1",  0,0, 0,12'h0, 0,12'h0, 12'h001,19'h100,  12'h001,0,0);
        step("run2",  0,0, 0,12'h0, 0,12'h0, 12'h002,19'h101,  12'h002,0,0);
        step("run3",  0,0, 0,12'h0, 0,12'h0, 12'h003,19'h102,  12'h003,0,0);
        step("run4",  0,0, 0,12'h0, 0,12'h0, 12'h004,19'h103,  12'h004,0,0);
        // Stall three cycles with pc_q = 5.
        for (int i = 0; i < 3; i++)
            step("stl",   0,1, 0,12'h0, 0,12'h0, 12'h004,19'h104,  12'h005,0,1);
        step("rel",   0,0, 0,12'h0, 0,12'h0, 12'h005,19'h104,  12'h005,0,0);
        step("run6",  0,0, 0,12'h0, 0,12'h0, 12'h006,19'h105,  12'h006,0,0);
        step("run7",  0,0, 0,12'h0, 0,12'h0, 12'h007,19'h106,  12'h007,0,0);
        // Taken branch at pc_q = 8.
        step("br",    0,0, 1,12'h0A0, 0,12'h0, 12'h008,19'h107,  12'h008,1,0);
        step("brn",   0,0, 0,12'h0, 0,12'h0, 12'h0A0,19'h0,    12'h009,0,0);
        step("brt",   0,0, 0,12'h0, 0,12'h0, 12'h0A1,19'h1A0,  12'h0A1,0,0);
        // Branch, jump and stall together: branch wins, stall ignored.
        step("all",   0,1, 1,12'h020, 1,12'h040, 12'h0A2,19'h1A1,12'h0A2,1,0);
        step("alln",  0,0, 0,12'h0, 0,12'h0, 12'h020,19'h0,    12'h0A3,0,0);
        step("allt",  0,0, 0,12'h0, 0,12'h0, 12'h021,19'h120,  12'h021,0,0);
        // Jump near the top of the address space, then wrap.
        step("jmp",   0,0, 0,12'h0, 1,12'hFFD, 12'h022,19'h121,  12'h022,1,0);
        step("jmpn",  0,0, 0,12'h0, 0,12'h0, 12'hFFD,19'h0,    12'h023,0,0);
        step("wr0",   0,0, 0,12'h0, 0,12'h0, 12'hFFE,19'h10FD, 12'hFFE,0,0);
        step("wr1",   0,0, 0,12'h0, 0,12'h0, 12'hFFF,19'h10FE, 12'hFFF,0,0);
        step("wr2",   0,0, 0,12'h0, 0,12'h0, 12'h000,19'h10FF, 12'h000,0,0);
        step("wr3",   0,0, 0,12'h0, 0,12'h0, 12'h001,19'h100,  12'h001,0,0);
        // Reach pc_q = 0x33 via a jump, then stall there.
        step("j32",   0,0, 0,12'h0, 1,12'h032, 12'h002,19'h101,  12'h002,1,0);
        step("j32n",  0,0, 0,12'h0, 0,12'h0, 12'h032,19'h0,    12'h003,0,0);
        step("s33",   0,1, 0,12'h0, 0,12'h0, 12'h032,19'h132,  12'h033,0,1);
        // Reset during the stall.
        step("rstl",  1,1, 0,12'h0, 0,12'h0, 12'h032,19'h132,  12'h033,0,1);
        step("prst",  0,1, 0,12'h0, 0,12'h0, 12'h000,19'h0,    12'h001,0,1);
        // Reset during a redirect: flush suppressed, target discarded.
        step("rbr",   1,0, 1,12'h055, 0,12'h0, 12'h000,19'h0,    12'h001,0,0);
        step("prb0",  0,0, 0,12'h0, 0,12'h0, 12'h000,19'h0,    12'h001,0,0);
        step("prb1",  0,0, 0,12'h0, 0,12'h0, 12'h001,19'h100,  12'h001,0,0);
        if (sb_q.size() != 0)
            check("sb_left", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
